fir_sequencer: RTL and testbench

FIR_SEQUENCER -- requirements
Module: fir_sequencer

---
 rtl/fir_sequencer.sv | 152 +++++++++++++++
 tb/tb_fir_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// fir_sequencer
// Control sequencer for a folded symmetric FIR filter. A free-running divider
// produces the sample strobe; each accepted strobe starts one pass that steps
// the folded-tap index through 0..NUM_TAPS-1 (one MAC per cycle), then flags
// the finished output for one cycle. Strobes that arrive while a pass is still
// running are dropped and recorded in a sticky overrun flag and a saturating
// drop counter.
//
// Parameters
//   SAMPLE_DIV  clock cycles per sample strobe (2..255)
//   NUM_TAPS    folded-tap MAC cycles per sample (1..15)
//
// Ports
//   iClk_12M        in   single clock, rising edge
//   iRst            in   synchronous active-high reset
//   iEnable         in   level, permits starting a new sample pass
//   iClrErr         in   pulse, clears oOverrun and oDropCnt
//   oEnSample_600k  out  one-cycle sample strobe
//   oEnDelay        out  delay-chain shift enable
//   oTapSel[3:0]    out  folded-tap index for coefficient ROM / sum mux
//   oAccClr         out  load accumulator with current product (tap 0)
//   oAccEn          out  accumulate enable
//   oOutValid       out  one-cycle pulse, accumulator holds finished output
//   oBusy           out  a pass is in progress
//   oOverrun        out  sticky, a strobe arrived while busy
//   oDropCnt[7:0]   out  saturating count of dropped samples
module fir_sequencer #(
    parameter int SAMPLE_DIV = 20,
    parameter int NUM_TAPS   = 12
) (
    input  logic       iClk_12M,
    input  logic       iRst,
    input  logic       iEnable,
    input  logic       iClrErr,
    output logic       oEnSample_600k,
    output logic       oEnDelay,
    output logic [3:0] oTapSel,
    output logic       oAccClr,
    output logic       oAccEn,
    output logic       oOutValid,
    output logic       oBusy,
    output logic       oOverrun,
    output logic [7:0] oDropCnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
    localparam logic [3:0] TAP_LAST = 4'(NUM_TAPS - 1);

    logic [7:0] cnt_q, cnt_d;
    state_t     state_q, state_d;
    logic [3:0] tap_q, tap_d;
    logic       overrun_q, overrun_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    logic       strobe;
    logic       drop_evt;

    // Strobe divider: runs regardless of enable or sequencer state so the
    // sample rate never drifts.
    always_comb begin
        strobe = (cnt_q == DIV_LAST);
        if (strobe) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Sequencer next-state and per-state outputs
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        oTapSel   = 4'd0;
        oAccEn    = 1'b0;
        oAccClr   = 1'b0;
        oOutValid = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe && iEnable) begin
                    state_d = ACC;
                    tap_d   = 4'd0;
                end
            end
            ACC: begin
                oTapSel = tap_q;
                oAccEn  = 1'b1;
                // First tap loads the accumulator instead of adding to stale data
                oAccClr = (tap_q == 4'd0);
                if (tap_q == TAP_LAST) begin
                    state_d = DONE;
                    tap_d   = 4'd0;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            DONE: begin
                oOutValid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                tap_d   = 4'd0;
            end
        endcase
    end

    // Overrun bookkeeping. A drop in the same cycle as a clear wins, so the
    // event is never lost: the flag stays set and the count restarts at 1.
    always_comb begin
        drop_evt   = strobe && (state_q != IDLE);
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        if (iClrErr) begin
            overrun_d  = drop_evt;
            drop_cnt_d = drop_evt ? 8'd1 : 8'd0;
        end else if (drop_evt) begin
            overrun_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            cnt_q      <= 8'd0;
            state_q    <= IDLE;
            tap_q      <= 4'd0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            tap_q      <= tap_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign oEnSample_600k = strobe;
    assign oEnDelay       = (state_q == IDLE) && iEnable;
    assign oBusy          = (state_q != IDLE);
    assign oOverrun       = overrun_q;
    assign oDropCnt       = drop_cnt_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer
// Two sequencer instances share one clock: instance A uses the default
// parameters (20-cycle sample period, 12 taps), instance B a 10-cycle period
// with 12 taps so that passes overrun. Each cycle the stimulus process asks a
// behavioural model (sample times and pass windows computed arithmetically)
// for the expected outputs and queues them; the monitor pops and compares on
// the falling edge.
module tb_fir_sequencer;

    localparam int A_DIV = 20;
    localparam int A_N   = 12;
    localparam int B_DIV = 10;
    localparam int B_N   = 12;

    typedef struct packed {
        int         cyc;
        logic       strobe;
        logic       endelay;
        logic [3:0] tapsel;
        logic       clr;
        logic       en;
        logic       valid;
        logic       busy;
        logic       ovr;
        logic [7:0] drops;
    } exp_t;

    typedef struct {
        int   k;       // cycles since last reset edge
        int   pass_t;  // cycle of the strobe that started the running pass, -1 if none
        logic ovr;
        int   drops;
        logic known;
    } mstate_t;

    logic clk;
    int   cyc;
    int   checks;
    int   errors;

    logic       rst_a, en_a, clr_a;
    logic       smp_a, dly_a, aclr_a, aen_a, val_a, busy_a, ovr_a;
    logic [3:0] tap_a;
    logic [7:0] drp_a;

    logic       rst_b, en_b, clr_b;
    logic       smp_b, dly_b, aclr_b, aen_b, val_b, busy_b, ovr_b;
    logic [3:0] tap_b;
    logic [7:0] drp_b;

    mstate_t ms[2];
    exp_t    qa[$];
    exp_t    qb[$];
    exp_t    mon_e;
    exp_t    mon_act;

    fir_sequencer u_dut_a (
        .iClk_12M       (clk),
        .iRst           (rst_a),
        .iEnable        (en_a),
        .iClrErr        (clr_a),
        .oEnSample_600k (smp_a),
        .oEnDelay       (dly_a),
        .oTapSel        (tap_a),
        .oAccClr        (aclr_a),
        .oAccEn         (aen_a),
        .oOutValid      (val_a),
        .oBusy          (busy_a),
        .oOverrun       (ovr_a),
        .oDropCnt       (drp_a)
    );

    fir_sequencer #(.SAMPLE_DIV(B_DIV), .NUM_TAPS(B_N)) u_dut_b (
        .iClk_12M       (clk),
        .iRst           (rst_b),
        .iEnable        (en_b),
        .iClrErr        (clr_b),
        .oEnSample_600k (smp_b),
        .oEnDelay       (dly_b),
        .oTapSel        (tap_b),
        .oAccClr        (aclr_b),
        .oAccEn         (aen_b),
        .oOutValid      (val_b),
        .oBusy          (busy_b),
        .oOverrun       (ovr_b),
        .oDropCnt       (drp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs in the current cycle, from sample timing and pass window
    function automatic exp_t model_out(mstate_t s, int div, int n, logic en);
        exp_t e;
        int   d;
        e = '0;
        e.strobe = ((s.k % div) == (div - 1));
        if (s.pass_t >= 0) begin
            d = s.k - s.pass_t;
            if (d >= 1 && d <= n) begin
                e.tapsel = 4'(d - 1);
                e.en     = 1'b1;
                e.clr    = (d == 1);
                e.busy   = 1'b1;
            end else if (d == n + 1) begin
                e.valid = 1'b1;
                e.busy  = 1'b1;
            end
        end
        e.endelay = !e.busy && en;
        e.ovr     = s.ovr;
        e.drops   = 8'(s.drops);
        return e;
    endfunction

    function automatic mstate_t model_next(mstate_t s, int div, int n,
                                           logic en, logic clr, logic rst);
        exp_t    e;
        mstate_t t;
        logic    ev;
        e = model_out(s, div, n, en);
        t = s;
        if (rst) begin
            t.k      = 0;
            t.pass_t = -1;
            t.ovr    = 1'b0;
            t.drops  = 0;
            t.known  = 1'b1;
            return t;
        end
        if (!s.known) return t;
        if (e.valid) t.pass_t = -1;
        if (e.strobe && !e.busy && en) t.pass_t = s.k;
        ev = e.strobe && e.busy;
        if (clr) begin
            t.ovr   = ev;
            t.drops = ev ? 1 : 0;
        end else if (ev) begin
            t.ovr = 1'b1;
            if (t.drops < 255) t.drops = t.drops + 1;
        end
        t.k = s.k + 1;
        return t;
    endfunction

    function automatic exp_t peek(int which);
        if (which == 0) return model_out(ms[0], A_DIV, A_N, 1'b1);
        return model_out(ms[1], B_DIV, B_N, 1'b1);
    endfunction

    // Drive one cycle of stimulus into an instance and queue its expectation
    task automatic step(input int which, input logic rst, input logic en, input logic clr);
        exp_t e;
        int   div;
        int   n;
        div = (which == 0) ? A_DIV : B_DIV;
        n   = (which == 0) ? A_N : B_N;
        @(posedge clk);
        #1;
        if (which == 0) begin
            rst_a = rst; en_a = en; clr_a = clr;
        end else begin
            rst_b = rst; en_b = en; clr_b = clr;
        end
        e     = model_out(ms[which], div, n, en);
        e.cyc = cyc;
        if (ms[which].known) begin
            if (which == 0) qa.push_back(e);
            else            qb.push_back(e);
        end
        ms[which] = model_next(ms[which], div, n, en, clr, rst);
    endtask

    task automatic chk(input string name, input int c, input logic [7:0] got,
                       input logic [7:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, got, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input exp_t a);
        chk({tag, ".strobe"},  e.cyc, {7'd0, a.strobe},  {7'd0, e.strobe});
        chk({tag, ".endelay"}, e.cyc, {7'd0, a.endelay}, {7'd0, e.endelay});
        chk({tag, ".tapsel"},  e.cyc, {4'd0, a.tapsel},  {4'd0, e.tapsel});
        chk({tag, ".accclr"},  e.cyc, {7'd0, a.clr},     {7'd0, e.clr});
        chk({tag, ".accen"},   e.cyc, {7'd0, a.en},      {7'd0, e.en});
        chk({tag, ".outvalid"},e.cyc, {7'd0, a.valid},   {7'd0, e.valid});
        chk({tag, ".busy"},    e.cyc, {7'd0, a.busy},    {7'd0, e.busy});
        chk({tag, ".overrun"}, e.cyc, {7'd0, a.ovr},     {7'd0, e.ovr});
        chk({tag, ".dropcnt"}, e.cyc, a.drops,           e.drops);
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0) begin
            mon_e   = qa.pop_front();
            mon_act = '0;
            mon_act.strobe  = smp_a;  mon_act.endelay = dly_a;
            mon_act.tapsel  = tap_a;  mon_act.clr     = aclr_a;
            mon_act.en      = aen_a;  mon_act.valid   = val_a;
            mon_act.busy    = busy_a; mon_act.ovr     = ovr_a;
            mon_act.drops   = drp_a;
            compare("a", mon_e, mon_act);
        end
        if (qb.size() > 0) begin
            mon_e   = qb.pop_front();
            mon_act = '0;
            mon_act.strobe  = smp_b;  mon_act.endelay = dly_b;
            mon_act.tapsel  = tap_b;  mon_act.clr     = aclr_b;
            mon_act.en      = aen_b;  mon_act.valid   = val_b;
            mon_act.busy    = busy_b; mon_act.ovr     = ovr_b;
            mon_act.drops   = drp_b;
            compare("b", mon_e, mon_act);
        end
    end

    task automatic run_a();
        int guard;
        repeat (3)   step(0, 1'b1, 1'b0, 1'b0);
        // Enabled from reset: strobes 19/39/59, pass 20..31, valid 32
        repeat (70)  step(0, 1'b0, 1'b1, 1'b0);
        // Disabled: strobes continue, nothing else moves
        repeat (100) step(0, 1'b0, 1'b0, 1'b0);
        // Reset while tap 5 is presented
        guard = 0;
        while (!(peek(0).en && peek(0).tapsel == 4'd5) && guard < 100) begin
            step(0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        step(0, 1'b1, 1'b1, 1'b0);
        repeat (45)  step(0, 1'b0, 1'b1, 1'b0);
        // Enable dropped at tap 3: pass completes, no further pass
        guard = 0;
        while (!(peek(0).en && peek(0).tapsel == 4'd3) && guard < 100) begin
            step(0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        repeat (40)  step(0, 1'b0, 1'b0, 1'b0);
        // Random traffic
        repeat (400) step(0, $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 19) == 0);
    endtask

    task automatic run_b();
        int guard;
        repeat (2)  step(1, 1'b1, 1'b0, 1'b0);
        // First pass 10..21, strobe 19 dropped
        repeat (30) step(1, 1'b0, 1'b1, 1'b0);
        // Continuous run until the drop counter saturates, then beyond
        guard = 0;
        while (ms[1].drops < 255 && guard < 8000) begin
            step(1, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        repeat (40) step(1, 1'b0, 1'b1, 1'b0);
        // Clear coinciding with a drop strobe
        guard = 0;
        while (!(peek(1).strobe && peek(1).busy) && guard < 100) begin
            step(1, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        step(1, 1'b0, 1'b1, 1'b1);
        repeat (25) step(1, 1'b0, 1'b1, 1'b0);
        // Plain clear
        step(1, 1'b0, 1'b0, 1'b1);
        repeat (200) step(1, $urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 24) == 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_a = 1'b1; en_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0;
        ms[0] = '{k: 0, pass_t: -1, ovr: 1'b0, drops: 0, known: 1'b0};
        ms[1] = '{k: 0, pass_t: -1, ovr: 1'b0, drops: 0, known: 1'b0};
        fork
            run_a();
            run_b();
        join
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
